// File: rtl/channelizer_pkg.sv
// channelizer_pkg: reconfiguration FSM states and cfg word field positions
package channelizer_pkg;
  typedef enum logic [2:0] {RUN, WAIT_EOP, DRAIN, LOAD_COEF, LOAD_MASK, APPLY} state_t;
  localparam int CFG_LOAD_COEF = 13;
  localparam int CFG_LOAD_MASK = 12;
endpackage

// File: rtl/channelizer_reconfig_ctrl_axis_gate.sv
// axis_gate: combinational AXI-stream enable; payload always passes, handshake only when enabled
module axis_gate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] s_tdata,
  input  logic         s_tlast,
  input  logic         s_tvalid,
  output logic         s_tready,
  output logic [W-1:0] m_tdata,
  output logic         m_tlast,
  output logic         m_tvalid,
  input  logic         m_tready
);
  assign m_tdata  = s_tdata;
  assign m_tlast  = s_tlast;
  assign m_tvalid = en & s_tvalid;
  assign s_tready = en & m_tready;
endmodule

// File: rtl/channelizer_reconfig_ctrl.sv
// channelizer_reconfig_ctrl: gates samples at a packet boundary, drains, reloads coef/mask, applies fft_size
module channelizer_reconfig_ctrl
  import channelizer_pkg::*;
#(
  parameter logic [11:0] DEFAULT_FFT_SIZE = 12'd64,
  parameter int          DRAIN_CYCLES     = 256,
  parameter int          CNT_W            = 9
) (
  input  logic        ce_clk,
  input  logic        ce_rst_n,
  input  logic [13:0] s_cfg_tdata,
  input  logic        s_cfg_tvalid,
  output logic        s_cfg_tready,
  input  logic [31:0] s_data_tdata,
  input  logic        s_data_tlast,
  input  logic        s_data_tvalid,
  output logic        s_data_tready,
  output logic [31:0] m_data_tdata,
  output logic        m_data_tlast,
  output logic        m_data_tvalid,
  input  logic        m_data_tready,
  input  logic        mon_out_tvalid,
  input  logic        mon_out_tready,
  input  logic [31:0] s_coef_tdata,
  input  logic        s_coef_tlast,
  input  logic        s_coef_tvalid,
  output logic        s_coef_tready,
  output logic [31:0] m_reload_tdata,
  output logic        m_reload_tlast,
  output logic        m_reload_tvalid,
  input  logic        m_reload_tready,
  input  logic [31:0] s_mask_tdata,
  input  logic        s_mask_tlast,
  input  logic        s_mask_tvalid,
  output logic        s_mask_tready,
  output logic [31:0] m_select_tdata,
  output logic        m_select_tlast,
  output logic        m_select_tvalid,
  input  logic        m_select_tready,
  output logic [11:0] fft_size,
  output logic        busy,
  output logic        reconfig_done,
  output logic [15:0] reconfig_count
);
  state_t state, next_state;
  logic in_pkt, data_hs, coef_hs, mask_hs, mon_hs, pkt_open, drained;
  logic [CNT_W-1:0] drain_cnt;

  axis_gate #(.W(32)) u_data_gate (
    .en(state == RUN || state == WAIT_EOP),
    .s_tdata(s_data_tdata), .s_tlast(s_data_tlast), .s_tvalid(s_data_tvalid), .s_tready(s_data_tready),
    .m_tdata(m_data_tdata), .m_tlast(m_data_tlast), .m_tvalid(m_data_tvalid), .m_tready(m_data_tready)
  );

  axis_gate #(.W(32)) u_coef_gate (
    .en(state == LOAD_COEF),
    .s_tdata(s_coef_tdata), .s_tlast(s_coef_tlast), .s_tvalid(s_coef_tvalid), .s_tready(s_coef_tready),
    .m_tdata(m_reload_tdata), .m_tlast(m_reload_tlast), .m_tvalid(m_reload_tvalid), .m_tready(m_reload_tready)
  );

  axis_gate #(.W(32)) u_mask_gate (
    .en(state == LOAD_MASK),
    .s_tdata(s_mask_tdata), .s_tlast(s_mask_tlast), .s_tvalid(s_mask_tvalid), .s_tready(s_mask_tready),
    .m_tdata(m_select_tdata), .m_tlast(m_select_tlast), .m_tvalid(m_select_tvalid), .m_tready(m_select_tready)
  );

  assign data_hs       = s_data_tvalid & s_data_tready;
  assign coef_hs       = s_coef_tvalid & s_coef_tready;
  assign mask_hs       = s_mask_tvalid & s_mask_tready;
  assign mon_hs        = mon_out_tvalid & mon_out_tready;
  assign pkt_open      = data_hs ? ~s_data_tlast : in_pkt;
  assign drained       = drain_cnt == CNT_W'(DRAIN_CYCLES - 1) && !mon_hs;
  assign busy          = state != RUN;
  assign reconfig_done = state == APPLY;
  assign s_cfg_tready  = state == APPLY;

  // next-state: wait for a packet boundary, drain, optional loads, then one APPLY cycle
  always_comb begin
    next_state = state;
    unique case (state)
      RUN:       if (s_cfg_tvalid) next_state = pkt_open ? WAIT_EOP : DRAIN;
      WAIT_EOP:  if (data_hs && s_data_tlast) next_state = DRAIN;
      DRAIN:     if (drained) next_state = s_cfg_tdata[CFG_LOAD_COEF] ? LOAD_COEF :
                                           s_cfg_tdata[CFG_LOAD_MASK] ? LOAD_MASK : APPLY;
      LOAD_COEF: if (coef_hs && s_coef_tlast) next_state = s_cfg_tdata[CFG_LOAD_MASK] ? LOAD_MASK : APPLY;
      LOAD_MASK: if (mask_hs && s_mask_tlast) next_state = APPLY;
      APPLY:     next_state = RUN;
      default:   next_state = RUN;
    endcase
  end

  // state register
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) state <= RUN;
    else state <= next_state;
  end

  // packet tracking, drain idle counter, active fft_size and completion count
  always_ff @(posedge ce_clk or negedge ce_rst_n) begin
    if (!ce_rst_n) begin
      in_pkt         <= 1'b0;
      drain_cnt      <= '0;
      fft_size       <= DEFAULT_FFT_SIZE;
      reconfig_count <= '0;
    end else begin
      in_pkt    <= pkt_open;
      drain_cnt <= (state != DRAIN || mon_hs) ? '0 : drain_cnt + 1'b1;
      if (state == APPLY) begin
        fft_size       <= s_cfg_tdata[11:0];
        reconfig_count <= reconfig_count + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_channelizer_reconfig_ctrl.sv
// tb_channelizer_reconfig_ctrl: randomized traffic checked every cycle against a request-level model
module tb_channelizer_reconfig_ctrl;
  logic        ce_clk = 1'b0, ce_rst_n = 1'b0;
  logic [13:0] s_cfg_tdata;
  logic        s_cfg_tvalid, s_cfg_tready;
  logic [31:0] s_data_tdata, m_data_tdata, s_coef_tdata, m_reload_tdata, s_mask_tdata, m_select_tdata;
  logic        s_data_tlast, s_data_tvalid, s_data_tready, m_data_tlast, m_data_tvalid, m_data_tready;
  logic        mon_out_tvalid, mon_out_tready;
  logic        s_coef_tlast, s_coef_tvalid, s_coef_tready, m_reload_tlast, m_reload_tvalid, m_reload_tready;
  logic        s_mask_tlast, s_mask_tvalid, s_mask_tready, m_select_tlast, m_select_tvalid, m_select_tready;
  logic [11:0] fft_size;
  logic        busy, reconfig_done;
  logic [15:0] reconfig_count;

  channelizer_reconfig_ctrl dut (
    .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
    .s_cfg_tdata(s_cfg_tdata), .s_cfg_tvalid(s_cfg_tvalid), .s_cfg_tready(s_cfg_tready),
    .s_data_tdata(s_data_tdata), .s_data_tlast(s_data_tlast), .s_data_tvalid(s_data_tvalid), .s_data_tready(s_data_tready),
    .m_data_tdata(m_data_tdata), .m_data_tlast(m_data_tlast), .m_data_tvalid(m_data_tvalid), .m_data_tready(m_data_tready),
    .mon_out_tvalid(mon_out_tvalid), .mon_out_tready(mon_out_tready),
    .s_coef_tdata(s_coef_tdata), .s_coef_tlast(s_coef_tlast), .s_coef_tvalid(s_coef_tvalid), .s_coef_tready(s_coef_tready),
    .m_reload_tdata(m_reload_tdata), .m_reload_tlast(m_reload_tlast), .m_reload_tvalid(m_reload_tvalid), .m_reload_tready(m_reload_tready),
    .s_mask_tdata(s_mask_tdata), .s_mask_tlast(s_mask_tlast), .s_mask_tvalid(s_mask_tvalid), .s_mask_tready(s_mask_tready),
    .m_select_tdata(m_select_tdata), .m_select_tlast(m_select_tlast), .m_select_tvalid(m_select_tvalid), .m_select_tready(m_select_tready),
    .fft_size(fft_size), .busy(busy), .reconfig_done(reconfig_done), .reconfig_count(reconfig_count)
  );

  always #5 ce_clk = ~ce_clk;

  int vecs = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // stimulus controls written by the main sequence only
  int data_mode, sink_rand, mon_rand, mon_force, cfg_req_id, cfg_beat, c_len, c_gen, m_len, m_gen, pkt_fix;
  logic [13:0] cfg_word;

  // actual handshakes latched at the falling edge, consumed by the source driver
  logic a_d = 0, a_c = 0, a_m = 0, a_cfg = 0;

  // sources and sinks: driven 2 time units after each rising edge
  initial begin
    int beat, pkt_len, c_idx, c_seen, m_idx, m_seen, cfg_seen;
    beat = 0; pkt_len = 1; c_idx = 0; c_seen = 0; m_idx = 0; m_seen = 0; cfg_seen = 0;
    s_cfg_tvalid = 0; s_cfg_tdata = 0; s_data_tvalid = 0; s_data_tdata = 0; s_data_tlast = 0;
    s_coef_tvalid = 0; s_coef_tdata = 0; s_coef_tlast = 0; s_mask_tvalid = 0; s_mask_tdata = 0; s_mask_tlast = 0;
    m_data_tready = 1; m_reload_tready = 1; m_select_tready = 1; mon_out_tvalid = 0; mon_out_tready = 0;
    forever begin
      @(posedge ce_clk);
      #2;
      if (!ce_rst_n) begin
        s_cfg_tvalid = 0; cfg_seen = cfg_req_id;
        s_coef_tvalid = 0; c_idx = c_len; c_seen = c_gen;
        s_mask_tvalid = 0; m_idx = m_len; m_seen = m_gen;
      end else begin
        if (a_d) begin
          beat = s_data_tlast ? 0 : beat + 1;
          s_data_tvalid = 0;
        end
        if (!s_data_tvalid && (data_mode != 0 || beat != 0) && (data_mode != 1 || $urandom_range(1, 0) == 1)) begin
          if (beat == 0) pkt_len = data_mode == 1 ? int'($urandom_range(6, 1)) : pkt_fix;
          s_data_tvalid = 1; s_data_tdata = $urandom; s_data_tlast = beat == pkt_len - 1;
        end
        if (a_cfg) s_cfg_tvalid = 0;
        if (!s_cfg_tvalid && cfg_seen != cfg_req_id && (cfg_beat < 0 || (s_data_tvalid && beat == cfg_beat))) begin
          s_cfg_tvalid = 1; s_cfg_tdata = cfg_word; cfg_seen = cfg_req_id;
        end
        if (c_seen != c_gen) begin c_seen = c_gen; c_idx = 0; s_coef_tvalid = 0; end
        else if (a_c) begin c_idx++; s_coef_tvalid = 0; end
        if (!s_coef_tvalid && c_idx < c_len && (sink_rand == 0 || $urandom_range(1, 0) == 1)) begin
          s_coef_tvalid = 1; s_coef_tdata = {8'hC0, 8'(c_gen), 16'(c_idx)}; s_coef_tlast = c_idx == c_len - 1;
        end
        if (m_seen != m_gen) begin m_seen = m_gen; m_idx = 0; s_mask_tvalid = 0; end
        else if (a_m) begin m_idx++; s_mask_tvalid = 0; end
        if (!s_mask_tvalid && m_idx < m_len && (sink_rand == 0 || $urandom_range(1, 0) == 1)) begin
          s_mask_tvalid = 1; s_mask_tdata = {8'h5E, 8'(m_gen), 16'(m_idx)}; s_mask_tlast = m_idx == m_len - 1;
        end
      end
      m_data_tready   = sink_rand == 0 || $urandom_range(1, 0) == 1;
      m_reload_tready = sink_rand == 0 || $urandom_range(1, 0) == 1;
      m_select_tready = sink_rand == 0 || $urandom_range(1, 0) == 1;
      mon_out_tvalid  = mon_force != 0 || (mon_rand != 0 && $urandom_range(1023, 0) == 0);
      mon_out_tready  = mon_out_tvalid || $urandom_range(1, 0) == 1;
    end
  end

  // request-level model: a pending request, whether its packet boundary was seen,
  // how many consecutive idle output cycles followed, and which reloads remain
  bit req = 0, bnd = 0, need_c = 0, need_m = 0, pkt = 0, f_ok = 0;
  int idle = 0;
  logic [11:0] mfft = 12'd64;
  logic [15:0] mcnt = 0;
  bit f_d, f_dl, f_cl, f_ml, f_mon, f_cv;
  logic [13:0] f_cw;
  int cfg_hs = 0, d_total = 0, exp_c_idx = 0, exp_m_idx = 0, sc_gen = 0, sm_gen = 0;

  // single compare process: advance the model over the last edge, then check every output
  always @(negedge ce_clk) begin
    bit gate, drained, in_coef, in_mask, applying;
    if (!ce_rst_n) begin
      req = 0; bnd = 0; need_c = 0; need_m = 0; pkt = 0; idle = 0; mfft = 12'd64; mcnt = 0;
    end else if (f_ok) begin
      if (!req) begin
        if (f_cv) begin
          req = 1; bnd = !(f_d ? !f_dl : pkt); idle = 0; need_c = f_cw[13]; need_m = f_cw[12];
        end
      end else if (!bnd) begin
        if (f_d && f_dl) bnd = 1;
      end else if (idle < 256) idle = f_mon ? 0 : idle + 1;
      else if (need_c) begin
        if (f_cl) need_c = 0;
      end else if (need_m) begin
        if (f_ml) need_m = 0;
      end else begin
        req = 0; mfft = f_cw[11:0]; mcnt = mcnt + 16'd1;
      end
      if (f_d) pkt = !f_dl;
    end
    gate     = !(req && bnd);
    drained  = req && bnd && idle >= 256;
    in_coef  = drained && need_c;
    in_mask  = drained && !need_c && need_m;
    applying = drained && !need_c && !need_m;
    chk("busy", busy, req);
    chk("reconfig_done", reconfig_done, applying);
    chk("s_cfg_tready", s_cfg_tready, applying);
    chk("fft_size", fft_size, mfft);
    chk("reconfig_count", reconfig_count, mcnt);
    chk("m_data_tvalid", m_data_tvalid, gate && s_data_tvalid);
    chk("s_data_tready", s_data_tready, gate && m_data_tready);
    chk("m_reload_tvalid", m_reload_tvalid, in_coef && s_coef_tvalid);
    chk("s_coef_tready", s_coef_tready, in_coef && m_reload_tready);
    chk("m_select_tvalid", m_select_tvalid, in_mask && s_mask_tvalid);
    chk("s_mask_tready", s_mask_tready, in_mask && m_select_tready);
    if (gate && s_data_tvalid) begin
      chk("m_data_tdata", m_data_tdata, s_data_tdata);
      chk("m_data_tlast", m_data_tlast, s_data_tlast);
    end
    f_ok = ce_rst_n; f_d = gate && s_data_tvalid && m_data_tready; f_dl = s_data_tlast;
    f_cl = in_coef && s_coef_tvalid && m_reload_tready && s_coef_tlast;
    f_ml = in_mask && s_mask_tvalid && m_select_tready && s_mask_tlast;
    f_mon = mon_out_tvalid && mon_out_tready; f_cv = s_cfg_tvalid; f_cw = s_cfg_tdata;
    a_d = s_data_tvalid && s_data_tready; a_c = s_coef_tvalid && s_coef_tready;
    a_m = s_mask_tvalid && s_mask_tready; a_cfg = s_cfg_tvalid && s_cfg_tready;
    if (a_cfg) cfg_hs++;
    if (a_d) d_total++;
    if (sc_gen != c_gen) begin sc_gen = c_gen; exp_c_idx = 0; end
    if (sm_gen != m_gen) begin sm_gen = m_gen; exp_m_idx = 0; end
    if (m_reload_tvalid && m_reload_tready) begin
      chk("reload_word", m_reload_tdata, {8'hC0, 8'(c_gen), 16'(exp_c_idx)});
      chk("reload_last", m_reload_tlast, exp_c_idx == c_len - 1);
      exp_c_idx++;
    end
    if (m_select_tvalid && m_select_tready) begin
      chk("select_word", m_select_tdata, {8'h5E, 8'(m_gen), 16'(exp_m_idx)});
      chk("select_last", m_select_tlast, exp_m_idx == m_len - 1);
      exp_m_idx++;
    end
  end

  task automatic tick(input int k = 1);
    repeat (k) begin
      @(posedge ce_clk);
      #1;
    end
  endtask

  task automatic wait_done(input int bound, output int n);
    n = 0;
    while (!reconfig_done && n < bound) begin
      tick(1);
      n++;
    end
    chk("done_within_bound", reconfig_done, 1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", vecs, fails);
    $fatal(1);
  end

  // directed scenarios with literal expectations, interleaved with random traffic
  initial begin
    int n, snap;
    logic [13:0] w;
    data_mode = 0; sink_rand = 0; mon_rand = 0; mon_force = 0; cfg_req_id = 0; cfg_beat = -1;
    c_len = 0; c_gen = 0; m_len = 0; m_gen = 0; pkt_fix = 4; cfg_word = 0;
    tick(3);
    chk("reset_fft_size", fft_size, 12'd64);
    chk("reset_busy", busy, 0);
    chk("reset_count", reconfig_count, 0);
    chk("reset_done", reconfig_done, 0);
    ce_rst_n = 1; data_mode = 2;
    tick(2);
    #2;
    chk("pass_valid", m_data_tvalid, 1);
    chk("pass_data", m_data_tdata, s_data_tdata);
    data_mode = 1; sink_rand = 1;
    tick(200);
    data_mode = 0; sink_rand = 0;
    tick(20);

    cfg_word = 14'h0100; cfg_beat = -1; cfg_req_id++;
    tick(1);
    chk("idle_busy_rise", busy, 1);
    wait_done(400, n);
    chk("idle_drain_cycles", n, 256);
    tick(1);
    chk("idle_fft_size", fft_size, 12'd256);
    chk("idle_count", reconfig_count, 1);
    chk("idle_cfg_handshakes", cfg_hs, 1);

    pkt_fix = 10; c_len = 128; c_gen++; snap = d_total;
    cfg_word = 14'h2080; cfg_beat = 2; cfg_req_id++; data_mode = 2;
    wait_done(3000, n);
    chk("midpkt_beats_passed", d_total - snap, 10);
    chk("midpkt_coef_words", exp_c_idx, 128);
    data_mode = 0;
    tick(1);
    chk("midpkt_fft_size", fft_size, 12'd128);
    chk("midpkt_count", reconfig_count, 2);
    tick(30);

    cfg_word = 14'h0200; cfg_beat = -1; cfg_req_id++;
    tick(201);
    mon_force = 1;
    tick(1);
    mon_force = 0;
    wait_done(600, n);
    chk("restart_idle_cycles", n, 256);
    tick(1);
    chk("restart_fft_size", fft_size, 12'd512);
    chk("restart_count", reconfig_count, 3);

    c_len = 20; c_gen++; m_len = 12; m_gen++; sink_rand = 1; data_mode = 1; mon_rand = 1;
    cfg_word = 14'h3040; cfg_req_id++;
    wait_done(8000, n);
    chk("bp_coef_words", exp_c_idx, 20);
    chk("bp_mask_words", exp_m_idx, 12);
    tick(1);
    chk("bp_fft_size", fft_size, 12'd64);
    chk("bp_count", reconfig_count, 4);

    for (int i = 0; i < 4; i++) begin
      w = 14'($urandom);
      c_len = $urandom_range(8, 1); c_gen++; m_len = $urandom_range(8, 1); m_gen++;
      cfg_word = w; cfg_req_id++;
      wait_done(8000, n);
      if (w[13]) chk("rand_coef_words", exp_c_idx, c_len);
      if (w[12]) chk("rand_mask_words", exp_m_idx, m_len);
      tick(1);
      chk("rand_fft_size", fft_size, w[11:0]);
      chk("rand_count", reconfig_count, 5 + i);
    end
    data_mode = 0; sink_rand = 0; mon_rand = 0;
    tick(40);

    c_len = 128; c_gen++; cfg_word = 14'h2100; cfg_req_id++; snap = cfg_hs;
    n = 0;
    while (exp_c_idx < 50 && n < 2000) begin
      tick(1);
      n++;
    end
    chk("abort_reached_word50", exp_c_idx, 50);
    ce_rst_n = 0;
    #1;
    chk("abort_busy_async", busy, 0);
    chk("abort_cfg_ready", s_cfg_tready, 0);
    tick(2);
    ce_rst_n = 1; data_mode = 2;
    tick(10);
    chk("abort_no_cfg_ack", cfg_hs, snap);
    chk("abort_count", reconfig_count, 0);
    chk("abort_fft_size", fft_size, 12'd64);
    chk("abort_gate_valid", m_data_tvalid, 1);
    chk("abort_gate_ready", s_data_tready, 1);
    chk("abort_coef_stopped", exp_c_idx, 50);
    data_mode = 0;
    tick(30);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
